// File: rtl/imm_pack.sv
// Immediate encoder: validates a signed 64-bit immediate against a RISC-V style
// format and scatters it into the base instruction, through a 2-stage valid/ready pipe.
module imm_pack #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [63:0]          in_imm,
  input  logic [2:0]           in_type,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic [1:0]           out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_U = 3'b000;
  localparam logic [2:0] FMT_J = 3'b001;
  localparam logic [2:0] FMT_I = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_S = 3'b100;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_TYPE  = 2'b11;

  // Handshake: a stage takes new data when it is empty or its contents move
  // on in the same cycle; a transfer happens on valid && ready at posedge clk.
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  logic [31:0] s1_inst;
  logic [63:0] s1_imm;
  logic [2:0]  s1_type;

  logic [31:0] s2_inst;
  logic [1:0]  s2_err;

  logic        type_ok;
  logic        align_ok;
  logic        range_ok;
  logic [1:0]  s1_err;
  logic [31:0] merged;
  logic [31:0] s1_result;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid;
  assign out_inst  = s2_inst;
  assign out_err   = s2_err;

  // Range checks: every bit above the field MSB must replicate it.
  always_comb begin
    range_ok = 1'b0;
    case (s1_type)
      FMT_U: range_ok = (s1_imm[11:0] == 12'h000) &&
                        ((&s1_imm[63:31]) || !(|s1_imm[63:31]));
      FMT_J: range_ok = (&s1_imm[63:20]) || !(|s1_imm[63:20]);
      FMT_I: range_ok = (&s1_imm[63:11]) || !(|s1_imm[63:11]);
      FMT_B: range_ok = (&s1_imm[63:12]) || !(|s1_imm[63:12]);
      FMT_S: range_ok = (&s1_imm[63:11]) || !(|s1_imm[63:11]);
      default: range_ok = 1'b0;
    endcase
  end

  always_comb begin
    type_ok  = (s1_type <= FMT_S);
    align_ok = !(((s1_type == FMT_J) || (s1_type == FMT_B)) && s1_imm[0]);
    if (!type_ok) begin
      s1_err = ERR_TYPE;
    end else if (!align_ok) begin
      s1_err = ERR_ALIGN;
    end else if (!range_ok) begin
      s1_err = ERR_RANGE;
    end else begin
      s1_err = ERR_NONE;
    end
  end

  always_comb begin
    merged = s1_inst;
    case (s1_type)
      FMT_U: merged[31:12] = s1_imm[31:12];
      FMT_J: begin
        merged[31]    = s1_imm[20];
        merged[30:21] = s1_imm[10:1];
        merged[20]    = s1_imm[11];
        merged[19:12] = s1_imm[19:12];
      end
      FMT_I: merged[31:20] = s1_imm[11:0];
      FMT_B: begin
        merged[31]    = s1_imm[12];
        merged[30:25] = s1_imm[10:5];
        merged[11:8]  = s1_imm[4:1];
        merged[7]     = s1_imm[11];
      end
      FMT_S: begin
        merged[31:25] = s1_imm[11:5];
        merged[11:7]  = s1_imm[4:0];
      end
      default: merged = s1_inst;
    endcase
    s1_result = (s1_err == ERR_NONE) ? merged : s1_inst;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_inst  <= 32'h0;
      s1_imm   <= 64'h0;
      s1_type  <= 3'b000;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_inst <= in_inst;
        s1_imm  <= in_imm;
        s1_type <= in_type;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_inst  <= 32'h0;
      s2_err   <= ERR_NONE;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_inst <= s1_result;
        s2_err  <= s1_err;
      end
    end
  end

  // Only results actually taken downstream are counted; stalled ones wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (s2_valid && out_ready && (s2_err != ERR_NONE) &&
                 (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Directed bench for imm_pack: encodes, error codes, backpressure ordering,
// error counter (including a 2-bit saturating instance) and mid-flight reset.
module tb_imm_pack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready_b;
  logic [31:0] in_inst;
  logic [63:0] in_imm;
  logic [2:0]  in_type;
  logic        out_valid;
  logic        out_valid_b;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_inst_b;
  logic [1:0]  out_err;
  logic [1:0]  out_err_b;
  logic [15:0] err_count;
  logic [1:0]  err_count_b;

  int n_checks;
  int n_errors;

  logic [33:0] exp_q[$];

  imm_pack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_imm(in_imm), .in_type(in_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count)
  );

  imm_pack #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_inst(in_inst), .in_imm(in_imm), .in_type(in_type),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_inst(out_inst_b),
    .out_err(out_err_b), .err_count(err_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [63:0] imm, input logic [2:0] typ);
    in_inst = inst;
    in_imm  = imm;
    in_type = typ;
  endtask

  // One request with out_ready high: accept, check 2-cycle latency, consume.
  task automatic send(input string tag, input logic [31:0] inst, input logic [63:0] imm,
                      input logic [2:0] typ, input logic [31:0] exp_inst, input logic [1:0] exp_err);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    drive(inst, imm, typ);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_inst"}, 64'(out_inst), 64'(exp_inst));
    chk({tag, "_err"}, 64'(out_err), 64'(exp_err));
    step();
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] bp_inst[4];
  logic [63:0] bp_imm[4];
  logic [2:0]  bp_type[4];
  logic [31:0] bp_exp_inst[4];
  logic [1:0]  bp_exp_err[4];

  initial begin
    int idx;
    int got;
    logic [33:0] e;

    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(32'h0, 64'h0, 3'b000);

    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    send("i_neg1", 32'h00000013, 64'hFFFF_FFFF_FFFF_FFFF, 3'b010, 32'hFFF00013, 2'b00);
    send("b_ok", 32'h00000063, 64'h800, 3'b011, 32'h000000E3, 2'b00);
    send("b_range", 32'h00000063, 64'h1000, 3'b011, 32'h00000063, 2'b01);
    send("u_ok", 32'h00000037, 64'h12345000, 3'b000, 32'h12345037, 2'b00);
    send("u_range", 32'h00000037, 64'h12345001, 3'b000, 32'h00000037, 2'b01);
    send("j_align", 32'h0000006F, 64'h3, 3'b001, 32'h0000006F, 2'b10);
    chk("cnt_after3", 64'(err_count), 64'd3);
    chk("cnt_sat_after3", 64'(err_count_b), 64'd3);
    send("bad_type", 32'h00000013, 64'h0, 3'b111, 32'h00000013, 2'b11);
    send("s_ok", 32'h00000023, 64'h7FF, 3'b100, 32'h7E000FA3, 2'b00);
    send("s_range", 32'h00000023, 64'h800, 3'b100, 32'h00000023, 2'b01);
    send("j_neg2", 32'h0000006F, 64'hFFFF_FFFF_FFFF_FFFE, 3'b001, 32'hFFFFF06F, 2'b00);
    send("i_overwrite", 32'hFFFFFFFF, 64'h0, 3'b010, 32'h000FFFFF, 2'b00);
    chk("cnt_after5", 64'(err_count), 64'd5);
    chk("cnt_sat_after5", 64'(err_count_b), 64'd3);

    // Backpressure: four back-to-back requests against a stalled output.
    bp_inst[0] = 32'h00000037; bp_imm[0] = 64'h1;          bp_type[0] = 3'b000;
    bp_exp_inst[0] = 32'h00000037; bp_exp_err[0] = 2'b01;
    bp_inst[1] = 32'h00000013; bp_imm[1] = 64'h5;          bp_type[1] = 3'b010;
    bp_exp_inst[1] = 32'h00500013; bp_exp_err[1] = 2'b00;
    bp_inst[2] = 32'h00000063; bp_imm[2] = 64'h7FE;        bp_type[2] = 3'b011;
    bp_exp_inst[2] = 32'h7E000F63; bp_exp_err[2] = 2'b00;
    bp_inst[3] = 32'h00000033; bp_imm[3] = 64'h0;          bp_type[3] = 3'b101;
    bp_exp_inst[3] = 32'h00000033; bp_exp_err[3] = 2'b11;

    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) drive(bp_inst[idx], bp_imm[idx], bp_type[idx]);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back({bp_exp_inst[idx], bp_exp_err[idx]});
        idx++;
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      chk("bp_stall_inst", 64'(out_inst), 64'(bp_exp_inst[0]));
      chk("bp_stall_err", 64'(out_err), 64'(bp_exp_err[0]));
      chk("bp_stall_cnt", 64'(err_count), 64'd5);
      step();
    end

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) drive(bp_inst[idx], bp_imm[idx], bp_type[idx]);
      #1;
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bp_order_inst", 64'(out_inst), 64'(e[33:2]));
          chk("bp_order_err", 64'(out_err), 64'(e[1:0]));
        end else begin
          chk("bp_unexpected_out", 64'(out_valid), 64'd0);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({bp_exp_inst[idx], bp_exp_err[idx]});
        idx++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("bp_all_out", 64'(got), 64'd4);
    chk("bp_cnt", 64'(err_count), 64'd7);
    chk("bp_cnt_sat", 64'(err_count_b), 64'd3);

    // Reset with both stages occupied discards everything.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'h00000013, 64'h1, 3'b111);
    step();
    step();
    in_valid = 1'b0;
    #1;
    chk("rf_full_valid", 64'(out_valid), 64'd1);
    chk("rf_full_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rf_out_valid", 64'(out_valid), 64'd0);
    chk("rf_err_count", 64'(err_count), 64'd0);
    chk("rf_err_count_sat", 64'(err_count_b), 64'd0);
    chk("rf_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rf_no_ghost", 64'(out_valid), 64'd0);
    end
    chk("rf_cnt_hold", 64'(err_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
